// File: rtl/button_param_ctrl_pkg.sv
// button_param_ctrl_pkg: key FSM state encoding and event-bit indices shared by the button controller
package button_param_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} key_state_e;
  localparam int EV_UP = 0;
  localparam int EV_DOWN = 1;
  localparam int EV_SEL = 2;
endpackage

// File: rtl/button_param_ctrl_key_event_gen.sv
// key_event_gen: turns one debounced key level (i_key) into registered press/auto-repeat event pulses (o_event)
module key_event_gen
  import button_param_ctrl_pkg::*;
#(
  parameter int HOLD_TIME = 25_000_000,
  parameter int REPEAT_TIME = 5_000_000,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key,
  output logic o_event
);
  key_state_e state, state_n;
  logic [31:0] cnt, cnt_n;
  logic hist, ev_n;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      cnt <= '0;
      hist <= 1'b1;
      o_event <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      hist <= i_key;
      o_event <= ev_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ev_n = 1'b0;
    unique case (state)
      IDLE: if (i_key && !hist) begin
        ev_n = 1'b1;
        state_n = HOLD;
        cnt_n = '0;
      end
      HOLD: if (!i_key) begin
        state_n = IDLE;
        cnt_n = '0;
      end else if (REPEAT_EN && cnt == 32'(HOLD_TIME - 1)) begin
        ev_n = 1'b1;
        state_n = REPEAT;
        cnt_n = '0;
      end else if (REPEAT_EN) begin
        cnt_n = cnt + 32'd1;
      end
      REPEAT: if (!i_key) begin
        state_n = IDLE;
        cnt_n = '0;
      end else if (cnt == 32'(REPEAT_TIME - 1)) begin
        ev_n = 1'b1;
        cnt_n = '0;
      end else begin
        cnt_n = cnt + 32'd1;
      end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end
endmodule

// File: rtl/button_param_ctrl.sv
// button_param_ctrl: up/down/select keys edit N_PARAM saturating registers (o_param, o_sel, o_update pulse, o_sat flag)
module button_param_ctrl
  import button_param_ctrl_pkg::*;
#(
  parameter int HOLD_TIME = 25_000_000,
  parameter int REPEAT_TIME = 5_000_000,
  parameter int N_PARAM = 4,
  parameter int SEL_W = 2,
  parameter int WIDTH = 16,
  parameter int STEP = 1,
  parameter int PMIN = 0,
  parameter int PMAX = 65535,
  parameter int RESET_VAL = 0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key_up,
  input  logic i_key_down,
  input  logic i_key_sel,
  input  logic i_lock,
  output logic [N_PARAM*WIDTH-1:0] o_param,
  output logic [SEL_W-1:0] o_sel,
  output logic o_update,
  output logic o_sat
);
  localparam logic [WIDTH:0] STEP_X = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0] PMIN_X = (WIDTH + 1)'(PMIN);
  localparam logic [WIDTH:0] PMAX_X = (WIDTH + 1)'(PMAX);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_PARAM - 1);
  logic [2:0] ev;
  logic [WIDTH-1:0] params [N_PARAM];
  logic [WIDTH:0] cur, sum, dif, new_v;
  logic up_c, dn_c, clamp;
  key_event_gen #(.HOLD_TIME(HOLD_TIME), .REPEAT_TIME(REPEAT_TIME), .REPEAT_EN(1'b1)) u_up (
    .i_clk(i_clk), .i_reset(i_reset), .i_key(i_key_up), .o_event(ev[EV_UP]));
  key_event_gen #(.HOLD_TIME(HOLD_TIME), .REPEAT_TIME(REPEAT_TIME), .REPEAT_EN(1'b1)) u_down (
    .i_clk(i_clk), .i_reset(i_reset), .i_key(i_key_down), .o_event(ev[EV_DOWN]));
  key_event_gen #(.HOLD_TIME(HOLD_TIME), .REPEAT_TIME(REPEAT_TIME), .REPEAT_EN(1'b0)) u_sel (
    .i_clk(i_clk), .i_reset(i_reset), .i_key(i_key_sel), .o_event(ev[EV_SEL]));
  assign cur = {1'b0, params[o_sel]};
  assign sum = cur + STEP_X;
  assign dif = cur - STEP_X;
  assign up_c = sum > PMAX_X;
  assign dn_c = cur < STEP_X || dif < PMIN_X;
  assign new_v = ev[EV_UP] ? (up_c ? PMAX_X : sum) : (dn_c ? PMIN_X : dif);
  assign clamp = ev[EV_UP] ? up_c : dn_c;
  for (genvar g = 0; g < N_PARAM; g++) begin : g_out
    assign o_param[g*WIDTH +: WIDTH] = params[g];
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < N_PARAM; k++) params[k] <= RST_V;
      o_sel <= '0;
      o_update <= 1'b0;
      o_sat <= 1'b0;
    end else begin
      o_update <= 1'b0;
      if (!i_lock && ev[EV_SEL]) begin
        o_sel <= (o_sel == SEL_LAST) ? '0 : o_sel + 1'b1;
        o_sat <= 1'b0;
      end else if (!i_lock && (ev[EV_UP] ^ ev[EV_DOWN])) begin
        params[o_sel] <= new_v[WIDTH-1:0];
        o_sat <= clamp;
        o_update <= new_v != cur;
      end
    end
  end
endmodule

// File: tb/tb_button_param_ctrl.sv
// tb_button_param_ctrl: directed and randomized self-checking bench for button_param_ctrl against a behavioural model
module tb_button_param_ctrl;
  logic i_clk = 1'b0, i_reset = 1'b1;
  logic up = 1'b0, dn = 1'b0, sl = 1'b0, lock = 1'b0;
  logic [23:0] o_param;
  logic [1:0] o_sel;
  logic o_update, o_sat;
  int total = 0, bad = 0, n_upd;
  button_param_ctrl #(
    .HOLD_TIME(8), .REPEAT_TIME(4), .N_PARAM(3), .SEL_W(2), .WIDTH(8),
    .STEP(5), .PMIN(0), .PMAX(20), .RESET_VAL(10)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_key_up(up), .i_key_down(dn), .i_key_sel(sl),
    .i_lock(lock), .o_param(o_param), .o_sel(o_sel), .o_update(o_update), .o_sat(o_sat)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask
  int m_param [3];
  int m_sel, age [3], mp, mr;
  bit m_upd, m_sat, mc;
  bit prev [3], act [3], pend [3];
  logic [2:0] keys;
  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < 3; k++) begin
        m_param[k] = 10;
        prev[k] = 1'b1;
        act[k] = 1'b0;
        pend[k] = 1'b0;
        age[k] = 0;
      end
      m_sel = 0;
      m_upd = 1'b0;
      m_sat = 1'b0;
    end else begin
      m_upd = 1'b0;
      if (!lock && pend[2]) begin
        m_sel = (m_sel + 1) % 3;
        m_sat = 1'b0;
      end else if (!lock && pend[0] != pend[1]) begin
        mp = m_param[m_sel];
        mr = pend[0] ? mp + 5 : mp - 5;
        mc = 1'b0;
        if (mr > 20) begin mr = 20; mc = 1'b1; end
        if (mr < 0) begin mr = 0; mc = 1'b1; end
        m_upd = mr != mp;
        m_param[m_sel] = mr;
        m_sat = mc;
      end
      keys = {sl, dn, up};
      for (int k = 0; k < 3; k++) begin
        pend[k] = 1'b0;
        if (!keys[k]) act[k] = 1'b0;
        else if (!prev[k]) begin
          act[k] = 1'b1;
          age[k] = 0;
          pend[k] = 1'b1;
        end else if (act[k]) begin
          age[k]++;
          if (k != 2 && (age[k] == 8 || (age[k] > 8 && (age[k] - 8) % 4 == 0))) pend[k] = 1'b1;
        end
        prev[k] = keys[k];
      end
    end
  end
  always @(posedge i_clk) begin
    #2;
    chk("model_param", {8'(o_param[23:16]), 8'(o_param[15:8]), 8'(o_param[7:0])},
        {8'(m_param[2]), 8'(m_param[1]), 8'(m_param[0])});
    chk("model_sel", o_sel, 32'(m_sel));
    chk("model_update", o_update, m_upd);
    chk("model_sat", o_sat, m_sat);
  end
  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask
  task automatic pulse_reset();
    i_reset = 1'b1;
    tick(1);
    i_reset = 1'b0;
    tick(2);
  endtask
  initial begin
    tick(2);
    i_reset = 1'b0;
    tick(2);
    chk("reset_param", o_param, 24'h0a0a0a);
    chk("reset_sel", o_sel, 0);
    up = 1'b1;
    tick(1);
    chk("s1_before", o_param[7:0], 10);
    tick(1);
    chk("s1_p0", o_param[7:0], 15);
    chk("s1_upd", o_update, 1);
    chk("s1_sat", o_sat, 0);
    chk("s1_p12", o_param[23:8], 16'h0a0a);
    tick(1);
    up = 1'b0;
    chk("s1_upd_once", o_update, 0);
    tick(3);
    pulse_reset();
    n_upd = 0;
    up = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      n_upd += int'(o_update);
      if (k == 1) chk("s2_p0_15", o_param[7:0], 15);
      if (k == 9) chk("s2_p0_20", o_param[7:0], 20);
      if (k == 12) chk("s2_sat_before", o_sat, 0);
      if (k == 13) chk("s2_sat_after", o_sat, 1);
      if (k == 19) chk("s2_p0_hold", o_param[7:0], 20);
    end
    chk("s2_updates", n_upd, 2);
    i_reset = 1'b1;
    #1;
    chk("s6_param", o_param, 24'h0a0a0a);
    chk("s6_sel", o_sel, 0);
    chk("s6_sat", o_sat, 0);
    chk("s6_upd", o_update, 0);
    tick(1);
    i_reset = 1'b0;
    n_upd = 0;
    repeat (10) begin
      tick(1);
      n_upd += int'(o_update);
    end
    chk("s5_held_p0", o_param[7:0], 10);
    chk("s5_held_upd", n_upd, 0);
    up = 1'b0;
    tick(2);
    up = 1'b1;
    tick(2);
    chk("s5_repress", o_param[7:0], 15);
    up = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      sl = 1'b1;
      tick(1);
      sl = 1'b0;
      tick(2);
      chk("s3_sel", o_sel, 32'((i + 1) % 3));
    end
    dn = 1'b1;
    tick(1);
    dn = 1'b0;
    tick(2);
    chk("s3_param", o_param, 24'h0a050f);
    up = 1'b1;
    dn = 1'b1;
    tick(1);
    up = 1'b0;
    dn = 1'b0;
    n_upd = 0;
    repeat (3) begin
      tick(1);
      n_upd += int'(o_update);
    end
    chk("s4_cancel_param", o_param, 24'h0a050f);
    chk("s4_cancel_upd", n_upd, 0);
    sl = 1'b1;
    up = 1'b1;
    tick(1);
    sl = 1'b0;
    up = 1'b0;
    tick(2);
    chk("s4_sel_wins_sel", o_sel, 2);
    chk("s4_sel_wins_param", o_param, 24'h0a050f);
    lock = 1'b1;
    up = 1'b1;
    tick(1);
    up = 1'b0;
    tick(2);
    chk("lock_param", o_param, 24'h0a050f);
    lock = 1'b0;
    tick(2);
    repeat (3000) begin
      tick(1);
      if ($urandom_range(9) == 0) up = ~up;
      if ($urandom_range(9) == 0) dn = ~dn;
      if ($urandom_range(13) == 0) sl = ~sl;
      lock = $urandom_range(7) == 0;
      if ($urandom_range(499) == 0) begin
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
      end
    end
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
